// File: rtl/sha3_axis_padder_if.sv
// Stream bundle around the SHA3 padder: message input, padded-block output and the per-message mode.
// slave is the padder's view; master is the upstream/downstream environment's view.
interface sha3_axis_padder_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0]   s_tdata;
   logic [DATA_WIDTH/8-1:0] s_tkeep;
   logic                    s_tvalid;
   logic                    s_tlast;
   logic                    s_tready;
   logic [1:0]              mode;
   logic [DATA_WIDTH-1:0]   m_tdata;
   logic                    m_tvalid;
   logic                    m_tready;
   logic                    m_tlast;
   logic                    m_tid;
   logic [1:0]              m_tuser;

   modport slave (
      input  s_tdata, s_tkeep, s_tvalid, s_tlast, mode, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tuser
   );

   modport master (
      output s_tdata, s_tkeep, s_tvalid, s_tlast, mode, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tuser
   );
endinterface

// File: rtl/sha3_axis_padder.sv
// SHA3 front-end: cuts an AXI-Stream byte message into rate blocks and appends pad10*1 padding.
// Define PAD_KECCAK_LEGACY_EN to pad with the original Keccak byte 0x01 instead of SHA3's 0x06.
module sha3_axis_padder #(
   parameter int DATA_WIDTH = 64
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   sha3_axis_padder_if.slave axis
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int NW = $clog2(NB) + 1;
   localparam int CW = $clog2(1152 / DATA_WIDTH);

`ifdef PAD_KECCAK_LEGACY_EN
   localparam logic [7:0] PADB = 8'h01;
`else
   localparam logic [7:0] PADB = 8'h06;
`endif

   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_PAD  = 2'd1,
      S_ZERO = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic                  first_q, first_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  tid_q, tid_d;
   logic [1:0]            user_q, user_d;

   logic [1:0]            eff_mode;
   logic [CW-1:0]         wpb_last;
   logic                  blk_end;
   logic                  load;
   logic                  s_ready;
   logic                  accept;
   logic                  emit;
   logic                  last_partial;
   logic                  fin;
   logic [NW-1:0]         keep_cnt;
   logic [DATA_WIDTH-1:0] pad_word;
   logic [DATA_WIDTH-1:0] tail_word;

   // The first beat of a message sees the live mode; every later word uses the latched copy.
   assign eff_mode = first_q ? axis.mode : user_q;

   always_comb begin
      case (eff_mode)
         2'd0:    wpb_last = CW'(1152 / DATA_WIDTH - 1);
         2'd1:    wpb_last = CW'(1088 / DATA_WIDTH - 1);
         2'd2:    wpb_last = CW'(832 / DATA_WIDTH - 1);
         default: wpb_last = CW'(576 / DATA_WIDTH - 1);
      endcase
   end

   assign blk_end = (wcnt_q == wpb_last);
   assign load    = ~valid_q | axis.m_tready;
   assign s_ready = ARESETn & (state_q == S_DATA) & load;
   assign accept  = axis.s_tvalid & s_ready;
   assign emit    = (state_q == S_DATA) ? accept : load;

   always_comb begin
      keep_cnt = '0;
      for (int k = 0; k < NB; k++) begin
         keep_cnt = keep_cnt + NW'(axis.s_tkeep[k]);
      end
   end

   assign last_partial = (keep_cnt != NW'(NB));

   // tkeep is contiguous from byte 0, so its popcount is the index of the pad byte.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         localparam logic [NW-1:0] IDX    = NW'(gi);
         localparam bit            IS_LOW = (gi == 0);
         localparam bit            IS_TOP = (gi == NB - 1);
         logic [7:0] top_bits;

         assign top_bits = (IS_TOP && blk_end) ? 8'h80 : 8'h00;
         assign pad_word[8*gi +: 8] =
            ((IDX < keep_cnt) ? axis.s_tdata[8*gi +: 8] :
             (IDX == keep_cnt) ? PADB : 8'h00) | top_bits;
         assign tail_word[8*gi +: 8] =
            ((IS_LOW && state_q == S_PAD) ? PADB : 8'h00) | top_bits;
      end
   endgenerate

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= S_DATA;
         wcnt_q  <= '0;
         first_q <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         tid_q   <= 1'b0;
         user_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         first_q <= first_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         tid_q   <= tid_d;
         user_q  <= user_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_DATA: begin
            if (accept && axis.s_tlast) begin
               if (!last_partial) begin
                  state_d = S_PAD;
               end else if (!blk_end) begin
                  state_d = S_ZERO;
               end
            end
         end
         S_PAD: begin
            if (load) begin
               state_d = blk_end ? S_DATA : S_ZERO;
            end
         end
         S_ZERO: begin
            if (load && blk_end) begin
               state_d = S_DATA;
            end
         end
         default: state_d = S_DATA;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      tid_d   = tid_q;
      user_d  = user_q;
      wcnt_d  = wcnt_q;
      first_d = first_q;
      valid_d = valid_q & ~axis.m_tready;
      fin     = 1'b0;
      if (emit) begin
         valid_d = 1'b1;
         user_d  = eff_mode;
         last_d  = blk_end;
         wcnt_d  = blk_end ? '0 : wcnt_q + 1'b1;
         if (state_q == S_DATA && !(axis.s_tlast && last_partial)) begin
            data_d = axis.s_tdata;
         end else if (state_q == S_DATA) begin
            data_d = pad_word;
            fin    = blk_end;
         end else begin
            data_d = tail_word;
            fin    = blk_end;
         end
         tid_d   = fin;
         first_d = fin;
      end
   end

   assign axis.s_tready = s_ready;
   assign axis.m_tdata  = data_q;
   assign axis.m_tvalid = valid_q;
   assign axis.m_tlast  = last_q;
   assign axis.m_tid    = tid_q;
   assign axis.m_tuser  = user_q;
endmodule
